rsmul_seq_core: RTL

Sequential two's-complement shift-and-add multiplier datapath with its own iteration control. It retires one multiplier bit per clock using an arithmetic right shift of the {P,Q} register pair. It sits directly downstream of the operand source and upstream of the product consumer. It uses a valid/ready handshake on both the operand side and the product side.

---
 rtl/rsmul_pkg.sv | 20 ++
 rtl/rsmul_step.sv | 38 +++
 rtl/rsmul_seq_core.sv | 102 ++++++++++
 3 files changed

// File: rtl/rsmul_pkg.sv
// Shared definitions for the rsmul sequential shift-and-add multiplier:
// FSM state encoding and an operand sign-extension helper.
package rsmul_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Widest operand the helper supports is EXT_W-1 bits.
  localparam int EXT_W = 65;

  // Replicate bit k-1 of v into every higher bit; callers keep bits [k:0].
  function automatic logic [EXT_W-1:0] sext_k1(input logic [EXT_W-2:0] v, input int k);
    logic [EXT_W-1:0] r;
    for (int i = 0; i < EXT_W; i++)
      r[i] = (i < k) ? v[i] : v[k-1];
    return r;
  endfunction

endpackage

// File: rtl/rsmul_step.sv
// One combinational multiplier iteration: conditional add (or subtract on the
// final signed step) of A into P, then a one-bit right shift of {P,Q}.
module rsmul_step
  import rsmul_pkg::*;
#(
  parameter int K = 8
) (
  input  logic [K:0]   p,
  input  logic [K-1:0] q,
  input  logic [K-1:0] a,
  input  logic         last,
  input  logic         tc,
  output logic [K:0]   p_next,
  output logic [K-1:0] q_next
);

  logic [EXT_W-1:0] a_wide;
  logic [K:0]       a_ext;
  logic [K:0]       addend;
  logic [K:0]       sum;
  logic             ext_unused;

  // Signed mode subtracts on the last step because the multiplier MSB has
  // negative weight; unsigned mode shifts the carry in without sign fill.
  always_comb begin
    a_wide = sext_k1((EXT_W-1)'(a), K);
    a_ext  = tc ? a_wide[K:0] : {1'b0, a};
    addend = '0;
    if (q[0])
      addend = (last && tc) ? -a_ext : a_ext;
    sum    = p + addend;
    p_next = {tc & sum[K], sum[K:1]};
    q_next = {sum[0], q[K-1:1]};
  end

  assign ext_unused = ^a_wide[EXT_W-1:K+1];

endmodule

// File: rtl/rsmul_seq_core.sv
// Sequential two's-complement multiplier, one multiplier bit per clock, with
// valid/ready on both sides. Define RSMUL_SIGN_SEL_EN to add the tc port.
module rsmul_seq_core
  import rsmul_pkg::*;
#(
  parameter  int K  = 8,
  localparam int CW = $clog2(K)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [K-1:0]   a,
  input  logic [K-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*K-1:0] product,
  output logic           busy
`ifdef RSMUL_SIGN_SEL_EN
  ,
  input  logic           tc
`endif
);

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [K:0]    p_reg;
  logic [K-1:0]  q_reg;
  logic [K-1:0]  a_reg;
  logic [CW-1:0] cnt;
  logic          tc_reg;
  logic          last;
  logic          accept;
  logic [K:0]    p_step;
  logic [K-1:0]  q_step;

  assign last   = (cnt == CW'(K-1));
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid)  state_next = S_RUN;
      S_RUN:   if (last)      state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default:                state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state == S_RUN) || (state == S_DONE);
  end

`ifdef RSMUL_SIGN_SEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         tc_reg <= 1'b1;
    else if (accept) tc_reg <= tc;
  end
`else
  assign tc_reg = 1'b1;
`endif

  rsmul_step #(.K(K)) u_step (
    .p      (p_reg),
    .q      (q_reg),
    .a      (a_reg),
    .last   (last),
    .tc     (tc_reg),
    .p_next (p_step),
    .q_next (q_step)
  );

  // The load edge only captures operands; arithmetic starts on the next edge.
  // The counter parks at K-1 so it never wraps while waiting in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_reg <= '0;
      q_reg <= '0;
      a_reg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      p_reg <= '0;
      q_reg <= b;
      a_reg <= a;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      p_reg <= p_step;
      q_reg <= q_step;
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  assign product = {p_reg[K-1:0], q_reg};

endmodule
